// File: rtl/bn_pkg.sv
// bn_pkg: shared constants and helpers for the batch-norm datapath.
//   FP16_W        element width of an IEEE half-precision sample
//   FP16_ZERO     +0.0, used to pad flushed vectors
//   FP16_EXP_MAX  all-ones exponent (NaN or Inf)
//   FP16_QUARTER  1/SIZE scale constant for the default SIZE=4 group
//   cnt_width()   element-index width, never narrower than one bit
//   fp16_exp()    exponent field of a sample
//   fp16_is_nan_inf()  sample is NaN or Inf
package bn_pkg;

    localparam int unsigned FP16_W       = 16;
    localparam logic [15:0] FP16_ZERO    = 16'h0000;
    localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
    localparam logic [15:0] FP16_QUARTER = 16'h3400;

    function automatic int unsigned cnt_width(input int unsigned vec);
        return (vec > 1) ? $clog2(vec) : 1;
    endfunction

    function automatic logic [4:0] fp16_exp(input logic [15:0] x);
        return x[14:10];
    endfunction

    function automatic logic fp16_is_nan_inf(input logic [15:0] x);
        return fp16_exp(x) == FP16_EXP_MAX;
    endfunction

endpackage

// File: rtl/bn_pack_bank.sv
// bn_pack_bank: one Vec-entry FP16 register bank of the ping-pong packer.
//   clk_i, rst_ni  clock, synchronous active-low reset
//   wr_en_i        write wr_data_i into element wr_idx_i
//   pad_en_i       zero every element at index >= pad_from_i
//   data_o         bank contents, element i at bits [i*FP16_W +: FP16_W]
//   nan_o          (BN_PACK_NAN_FLAG_EN only) some sample of this fill was NaN/Inf
module bn_pack_bank
    import bn_pkg::*;
#(
    parameter int unsigned Vec  = 4,
    parameter int unsigned CntW = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      wr_en_i,
    input  logic [CntW-1:0]           wr_idx_i,
    input  logic [FP16_W-1:0]         wr_data_i,
    input  logic                      pad_en_i,
    input  logic [CntW:0]             pad_from_i,
`ifdef BN_PACK_NAN_FLAG_EN
    output logic                      nan_o,
`endif
    output logic [0:FP16_W*Vec-1]     data_o
);

    logic [FP16_W-1:0] mem_q [Vec];

    // The caller never points pad_from_i at or below the element being written.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int e = 0; e < Vec; e++) mem_q[e] <= FP16_ZERO;
        end else begin
            for (int e = 0; e < Vec; e++) begin
                if (wr_en_i && (wr_idx_i == CntW'(e))) begin
                    mem_q[e] <= wr_data_i;
                end else if (pad_en_i && (pad_from_i <= (CntW + 1)'(e))) begin
                    mem_q[e] <= FP16_ZERO;
                end
            end
        end
    end

    always_comb begin
        data_o = '0;
        for (int e = 0; e < Vec; e++) data_o[e*FP16_W +: FP16_W] = mem_q[e];
    end

`ifdef BN_PACK_NAN_FLAG_EN
    logic nan_q;

    // Writing element 0 starts a new fill, so the old flag is dropped there.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            nan_q <= 1'b0;
        end else if (wr_en_i) begin
            nan_q <= ((wr_idx_i == '0) ? 1'b0 : nan_q) | fp16_is_nan_inf(wr_data_i);
        end
    end

    assign nan_o = nan_q;
`endif

endmodule

// File: rtl/bn_vec_packer.sv
// bn_vec_packer: serial-to-parallel FP16 packer feeding the batch-norm stage.
// Two banks ping-pong: one fills while the other is presented to the consumer.
//   clk, reset          clock, synchronous active-low reset
//   in_data/in_valid    one FP16 sample per handshake
//   in_ready            a sample or flush can be taken (registered state only)
//   flush               close the partial vector, zero-padding the tail
//   out_vec/out_valid   completed vector, element 0 in the leftmost bits
//   out_ready           consumer takes the vector
//   out_nan             present only with BN_PACK_NAN_FLAG_EN defined
module bn_vec_packer
    import bn_pkg::*;
#(
    parameter  int unsigned SIZE       = 4,
    parameter  int unsigned CHANNEL    = 1,
    localparam int unsigned DATA_WIDTH = FP16_W,
    localparam int unsigned VEC        = SIZE / CHANNEL
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [0:DATA_WIDTH*VEC-1]   out_vec,
    output logic                        out_valid,
    input  logic                        out_ready
`ifdef BN_PACK_NAN_FLAG_EN
    ,
    output logic                        out_nan
`endif
);

    localparam int unsigned CW = cnt_width(VEC);

    logic [CW-1:0] count_q, count_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [1:0]    full_q, full_d;

    logic          s_acc, f_acc, close, drain;
    logic [CW:0]   pad_from;
    logic [1:0]    bank_wr, bank_pad;
    logic [0:DATA_WIDTH*VEC-1] bank_data [2];
`ifdef BN_PACK_NAN_FLAG_EN
    logic [1:0]    bank_nan;
`endif

    always_comb begin
        in_ready = reset & ~full_q[wr_sel_q];
        s_acc    = in_valid & in_ready;
        // A flush on an empty bank with no sample alongside would make an empty vector.
        f_acc    = flush & in_ready & (s_acc | (count_q != '0));
        close    = f_acc | (s_acc & (count_q == CW'(VEC - 1)));
        drain    = full_q[rd_sel_q] & out_ready;
        // A same-cycle sample lands at count, so padding begins one past it.
        pad_from = s_acc ? ((CW + 1)'(count_q) + (CW + 1)'(1)) : (CW + 1)'(count_q);
        bank_wr  = {s_acc & wr_sel_q, s_acc & ~wr_sel_q};
        bank_pad = {f_acc & wr_sel_q, f_acc & ~wr_sel_q};
    end

    // Fill-complete and drain never address the same bank: close needs
    // !full[wr_sel] while drain needs full[rd_sel].
    always_comb begin
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        count_d  = count_q;
        if (close) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
            count_d          = '0;
        end else if (s_acc) begin
            count_d = count_q + CW'(1);
        end
        if (drain) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            count_q  <= '0;
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            count_q  <= count_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        bn_pack_bank #(
            .Vec  (VEC),
            .CntW (CW)
        ) u_bank (
            .clk_i      (clk),
            .rst_ni     (reset),
            .wr_en_i    (bank_wr[b]),
            .wr_idx_i   (count_q),
            .wr_data_i  (in_data),
            .pad_en_i   (bank_pad[b]),
            .pad_from_i (pad_from),
`ifdef BN_PACK_NAN_FLAG_EN
            .nan_o      (bank_nan[b]),
`endif
            .data_o     (bank_data[b])
        );
    end

    // Banks reset to zero, so out_vec reads zero out of reset.
    always_comb begin
        out_valid = full_q[rd_sel_q];
        out_vec   = bank_data[rd_sel_q];
    end

`ifdef BN_PACK_NAN_FLAG_EN
    assign out_nan = bank_nan[rd_sel_q];
`endif

endmodule

// File: tb/tb_bn_vec_packer.sv
// tb_bn_vec_packer: scoreboard bench for bn_vec_packer (SIZE=4, CHANNEL=1).
// A negedge monitor models accepted samples/flushes, queues expected vectors
// and compares each vector the consumer takes; scenario tasks check handshakes.
module tb_bn_vec_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [0:63] out_vec;
`ifdef BN_PACK_NAN_FLAG_EN
    logic        out_nan;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] exp_q [$];
    logic [15:0] m_vec [4];
    int          m_n = 0;
    logic [63:0] mon_e;
    logic [63:0] mon_v;

    bn_vec_packer #(
        .SIZE    (4),
        .CHANNEL (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_vec   (out_vec),
        .out_valid (out_valid),
`ifdef BN_PACK_NAN_FLAG_EN
        .out_nan   (out_nan),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            m_n = 0;
        end else begin
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_vector got %h required none", out_vec);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_vec !== mon_e) begin
                        miscompares++;
                        $display("FAIL vector_data got %h required %h", out_vec, mon_e);
                    end
                end
            end
            if (in_ready) begin
                if (in_valid) begin
                    m_vec[m_n] = in_data;
                    m_n++;
                end
                if (m_n == 4 || (flush && m_n > 0)) begin
                    mon_v = '0;
                    for (int i = 0; i < m_n; i++) mon_v[63-16*i -: 16] = m_vec[i];
                    exp_q.push_back(mon_v);
                    m_n = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one sample and hold it until accepted (bounded).
    task automatic put(input logic [15:0] d);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL put_timeout got not_accepted required accepted data %h", d);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        out_ready = 1'b0;
        cyc();
        cyc();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid got %b required 0", out_valid);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b required 0", in_ready);
        end
        vectors++;
        if (out_vec !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_out_vec got %h required 0", out_vec);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_in_ready got %b required 1", in_ready);
        end
        cyc();
    endtask

    task automatic test_basic_fill();
        out_ready = 1'b1;
        put(16'h3C00);
        put(16'h4000);
        put(16'h4200);
        put(16'h4400);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_out_valid got %b required 1", out_valid);
        end
        cyc();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_drained got %b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) put(16'h1000 + 16'(i));
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_both_full got rdy=%b vld=%b required rdy=0 vld=1",
                     in_ready, out_valid);
        end
        in_valid = 1'b1;
        in_data = 16'h1008;
        cyc();
        cyc();
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_stall got %b required 0", in_ready);
        end
        out_ready = 1'b1;
        cyc();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_ready_after_drain got %b required 1", in_ready);
        end
        cyc();
        in_valid = 1'b0;
        for (int i = 9; i < 12; i++) put(16'h1000 + 16'(i));
        for (int i = 0; i < 4; i++) cyc();
        vectors++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_all_drained got pending=%0d vld=%b required 0 0",
                     exp_q.size(), out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        put(16'h3C00);
        put(16'h4000);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_out_valid got %b required 1", out_valid);
        end
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_empty_ignored got %b required 0", out_valid);
        end
        cyc();
        vectors++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL flush_empty_quiet got vld=%b pending=%0d required 0 0",
                     out_valid, exp_q.size());
        end
        put(16'h4800);
        put(16'h4900);
        flush = 1'b1;
        put(16'h4A00);
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_with_sample got %b required 1", out_valid);
        end
        cyc();
        cyc();
    endtask

    task automatic test_concurrent();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(16'h2000 + 16'(i));
        for (int i = 0; i < 3; i++) put(16'h2100 + 16'(i));
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL conc_pre got vld=%b rdy=%b required 1 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        put(16'h2103);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL conc_both_flags got vld=%b rdy=%b required 1 1",
                     out_valid, in_ready);
        end
        cyc();
        vectors++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL conc_second_drain got vld=%b pending=%0d required 0 0",
                     out_valid, exp_q.size());
        end
    endtask

    task automatic test_reset_midfill();
        out_ready = 1'b1;
        put(16'h5000);
        put(16'h5001);
        reset = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midfill_in_ready_low got %b required 0", in_ready);
        end
        cyc();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midfill_in_reset got vld=%b rdy=%b required 0 0",
                     out_valid, in_ready);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midfill_ready_after got %b required 1", in_ready);
        end
        for (int i = 0; i < 4; i++) put(16'h5100 + 16'(i));
        cyc();
        cyc();
        vectors++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midfill_new_vector got pending=%0d vld=%b required 0 0",
                     exp_q.size(), out_valid);
        end
    endtask

`ifdef BN_PACK_NAN_FLAG_EN
    task automatic test_nan_flag();
        out_ready = 1'b0;
        put(16'h3C00);
        put(16'h7E00);
        put(16'h4000);
        put(16'h4200);
        vectors++;
        if (out_valid !== 1'b1 || out_nan !== 1'b1) begin
            miscompares++;
            $display("FAIL nan_set got vld=%b nan=%b required 1 1", out_valid, out_nan);
        end
        put(16'h3C00);
        put(16'h4000);
        put(16'h4200);
        put(16'h4400);
        out_ready = 1'b1;
        cyc();
        vectors++;
        if (out_valid !== 1'b1 || out_nan !== 1'b0) begin
            miscompares++;
            $display("FAIL nan_clear got vld=%b nan=%b required 1 0", out_valid, out_nan);
        end
        cyc();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_fill();
        test_backpressure();
        test_flush();
        test_concurrent();
        test_reset_midfill();
`ifdef BN_PACK_NAN_FLAG_EN
        test_nan_flag();
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL final_pending got %0d required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
